// File: rtl/scan_pkg.sv
// Shared types, default sizing and the one-hot helper for the digit scan driver.
package scan_pkg;

  typedef logic [3:0] hex_digit_t;

  localparam int NDIG_DEFAULT = 4;
  localparam int DIV_DEFAULT  = 4;
  localparam int ONEHOT_MAX   = 32;

  function automatic logic [ONEHOT_MAX-1:0] onehot(input int unsigned idx);
    return {{(ONEHOT_MAX-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot timer for the scan driver: divides the clock into DIV-cycle digit slots
// and walks the digit index, flagging the guard cycle and the frame boundary.
module scan_prescaler
  import scan_pkg::*;
#(
  parameter int NDIG = NDIG_DEFAULT,
  parameter int DIV  = DIV_DEFAULT
) (
  input  logic                    clk,
  input  logic                    nrst,
  output logic [$clog2(NDIG)-1:0] dig,
  output logic                    guard,
  output logic                    boundary
);

  localparam int DCW = $clog2(DIV);
  localparam int DGW = $clog2(NDIG);
  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
  localparam logic [DGW-1:0] DIG_LAST = DGW'(NDIG - 1);

  logic [DCW-1:0] div_cnt_q, div_cnt_d;
  logic [DGW-1:0] dig_q, dig_d;

  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    dig_d     = dig_q;
    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
      dig_d     = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      div_cnt_q <= '0;
      dig_q     <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      dig_q     <= dig_d;
    end
  end

  assign dig      = dig_q;
  assign guard    = (div_cnt_q == '0);
  assign boundary = (dig_q == DIG_LAST) && (div_cnt_q == DIV_LAST);

endmodule

// File: rtl/digit_scan_mux.sv
// Multiplexed hex display scan driver: one-entry input buffer, frame-aligned
// value swap, and per-slot nibble / digit-enable / blanking outputs.
module digit_scan_mux
  import scan_pkg::*;
#(
  parameter int NDIG = NDIG_DEFAULT,
  parameter int DIV  = DIV_DEFAULT
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] in_data,
  input  logic              in_lzb,
  output logic [3:0]        nibble,
  output logic [NDIG-1:0]   dig_en,
  output logic              blank,
  output logic              frame_tick
);

  localparam int DGW = $clog2(NDIG);
  localparam int W   = 4 * NDIG;

  logic [DGW-1:0] dig;
  logic           guard;
  logic           boundary;

  scan_prescaler #(.NDIG(NDIG), .DIV(DIV)) u_prescaler (
    .clk      (clk),
    .nrst     (nrst),
    .dig      (dig),
    .guard    (guard),
    .boundary (boundary)
  );

  logic [W-1:0] shown_q, shown_d;
  logic         lzb_q, lzb_d;
  logic [W-1:0] pend_q, pend_d;
  logic         pend_lzb_q, pend_lzb_d;
  logic         pend_v_q, pend_v_d;

  // A value accepted on the boundary cycle sees pend_v_q=0, so it waits a frame.
  always_comb begin
    shown_d    = shown_q;
    lzb_d      = lzb_q;
    pend_d     = pend_q;
    pend_lzb_d = pend_lzb_q;
    pend_v_d   = pend_v_q;
    if (pend_v_q && boundary) begin
      shown_d  = pend_q;
      lzb_d    = pend_lzb_q;
      pend_v_d = 1'b0;
    end else if (in_valid && !pend_v_q) begin
      pend_d     = in_data;
      pend_lzb_d = in_lzb;
      pend_v_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      shown_q    <= '0;
      lzb_q      <= 1'b0;
      pend_q     <= '0;
      pend_lzb_q <= 1'b0;
      pend_v_q   <= 1'b0;
    end else begin
      shown_q    <= shown_d;
      lzb_q      <= lzb_d;
      pend_q     <= pend_d;
      pend_lzb_q <= pend_lzb_d;
      pend_v_q   <= pend_v_d;
    end
  end

  hex_digit_t    nib;
  logic          upper_nz;
  logic [NDIG-1:0] sel_oh;

  always_comb begin
    nib      = shown_q[4*dig +: 4];
    upper_nz = 1'b0;
    for (int k = 0; k < NDIG; k++) begin
      if (k >= int'(dig) && shown_q[4*k +: 4] != 4'h0) upper_nz = 1'b1;
    end
    sel_oh = NDIG'(onehot(32'(dig)));
  end

  assign nibble     = nib;
  assign dig_en     = guard ? '0 : sel_oh;
  assign blank      = guard || (lzb_q && (dig != '0) && !upper_nz);
  assign frame_tick = boundary;
  assign in_ready   = !pend_v_q;

endmodule

// File: tb/tb_digit_scan_mux.sv
// Scoreboard bench for digit_scan_mux at NDIG=4, DIV=4 (16-cycle frames).
module tb_digit_scan_mux;

  typedef struct {
    logic [3:0] nib;
    logic       blk;
  } slot_t;

  logic        clk;
  logic        nrst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_lzb;
  logic [3:0]  nibble;
  logic [3:0]  dig_en;
  logic        blank;
  logic        frame_tick;

  int total;
  int bad;
  int tcyc;
  slot_t sb[$];

  digit_scan_mux #(.NDIG(4), .DIV(4)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_lzb     (in_lzb),
    .nibble     (nibble),
    .dig_en     (dig_en),
    .blank      (blank),
    .frame_tick (frame_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle index since reset release; cycle 0 is the first guard cycle.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) tcyc <= 0;
    else       tcyc <= tcyc + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic push_value(input logic [15:0] v, input logic lzb);
    slot_t e;
    for (int k = 0; k < 4; k++) begin
      e.nib = v[4*k +: 4];
      e.blk = lzb && (k >= 1) && ((v >> (4*k)) == 16'h0);
      sb.push_back(e);
    end
  endtask

  task automatic wait_phase(input int p);
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      if ((tcyc % 16) == p) break;
    end
  endtask

  // Called at the negedge of frame cycle 0; returns at cycle 0 of the next frame.
  task automatic check_frame(input string tag, input logic rdy_p0, input logic rdy_rest);
    slot_t      cur;
    logic [3:0] exp_en;
    logic       exp_rdy;
    cur.nib = 4'h0;
    cur.blk = 1'b1;
    for (int p = 0; p < 16; p++) begin
      int k;
      int d;
      k = p / 4;
      d = p % 4;
      if (d == 1) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL %s scoreboard empty at p=%0d", tag, p);
        end else begin
          cur = sb.pop_front();
        end
      end
      total++;
      if (frame_tick !== (p == 15)) begin
        bad++;
        $display("FAIL %s frame_tick p=%0d got %b want %b", tag, p, frame_tick, (p == 15));
      end
      exp_rdy = (p == 0) ? rdy_p0 : rdy_rest;
      total++;
      if (in_ready !== exp_rdy) begin
        bad++;
        $display("FAIL %s in_ready p=%0d got %b want %b", tag, p, in_ready, exp_rdy);
      end
      if (d == 0) begin
        total++;
        if (dig_en !== 4'b0000 || blank !== 1'b1) begin
          bad++;
          $display("FAIL %s guard p=%0d got en=%b blk=%b want en=0000 blk=1", tag, p, dig_en, blank);
        end
      end else begin
        exp_en = 4'b0001 << k;
        total++;
        if (dig_en !== exp_en || nibble !== cur.nib || blank !== cur.blk) begin
          bad++;
          $display("FAIL %s slot p=%0d got en=%b nib=%h blk=%b want en=%b nib=%h blk=%b",
                   tag, p, dig_en, nibble, blank, exp_en, cur.nib, cur.blk);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0; in_valid = 1'b0; in_data = 16'h0; in_lzb = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (dig_en !== 4'b0 || blank !== 1'b1 || nibble !== 4'h0 || in_ready !== 1'b1 || frame_tick !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold got en=%b blk=%b nib=%h rdy=%b ft=%b want en=0000 blk=1 nib=0 rdy=1 ft=0",
               dig_en, blank, nibble, in_ready, frame_tick);
    end
    @(posedge clk);
    #1 nrst = 1'b1;
    @(negedge clk);
    push_value(16'h0000, 1'b0);
    push_value(16'h0000, 1'b0);
    check_frame("reset_f0", 1'b1, 1'b1);
    check_frame("reset_f1", 1'b1, 1'b1);
  endtask

  task automatic test_load(input string tag, input logic [15:0] v, input logic lzb);
    wait_phase(5);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s ready_before got %b want 1", tag, in_ready);
    end
    in_valid = 1'b1; in_data = v; in_lzb = lzb;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s ready_after_accept got %b want 0", tag, in_ready);
    end
    push_value(v, lzb);
    wait_phase(0);
    check_frame(tag, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    wait_phase(5);
    in_valid = 1'b1; in_data = 16'h3C7E; in_lzb = 1'b0;
    @(negedge clk);
    in_data = 16'h0908; in_lzb = 1'b1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_stall got in_ready=%b want 0", in_ready);
    end
    push_value(16'h3C7E, 1'b0);
    push_value(16'h0908, 1'b1);
    wait_phase(0);
    check_frame("b2b_a", 1'b1, 1'b0);
    in_valid = 1'b0;
    check_frame("b2b_b", 1'b1, 1'b1);
  endtask

  task automatic test_boundary_accept();
    wait_phase(15);
    total++;
    if (in_ready !== 1'b1 || frame_tick !== 1'b1) begin
      bad++;
      $display("FAIL bnd_setup got rdy=%b ft=%b want rdy=1 ft=1", in_ready, frame_tick);
    end
    in_valid = 1'b1; in_data = 16'hBEEF; in_lzb = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    push_value(16'h0908, 1'b1);
    push_value(16'hBEEF, 1'b0);
    check_frame("bnd_old", 1'b0, 1'b0);
    check_frame("bnd_new", 1'b1, 1'b1);
  endtask

  task automatic test_reset_midframe();
    wait_phase(5);
    in_valid = 1'b1; in_data = 16'h5555; in_lzb = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    wait_phase(9);
    total++;
    if (dig_en !== 4'b0100 || nibble !== 4'hE || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_pre got en=%b nib=%h rdy=%b want en=0100 nib=e rdy=0", dig_en, nibble, in_ready);
    end
    #2 nrst = 1'b0;
    #1;
    total++;
    if (dig_en !== 4'b0 || blank !== 1'b1 || nibble !== 4'h0 || in_ready !== 1'b1 || frame_tick !== 1'b0) begin
      bad++;
      $display("FAIL rst_async got en=%b blk=%b nib=%h rdy=%b ft=%b want en=0000 blk=1 nib=0 rdy=1 ft=0",
               dig_en, blank, nibble, in_ready, frame_tick);
    end
    @(posedge clk);
    @(posedge clk);
    #1 nrst = 1'b1;
    @(negedge clk);
    push_value(16'h0000, 1'b0);
    push_value(16'h0000, 1'b0);
    check_frame("rst_f0", 1'b1, 1'b1);
    check_frame("rst_f1", 1'b1, 1'b1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_load("load_12af", 16'h12AF, 1'b0);
    test_load("load_0050", 16'h0050, 1'b1);
    test_load("load_0000", 16'h0000, 1'b1);
    test_back_to_back();
    test_boundary_accept();
    test_reset_midframe();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/digit_scan_mux.md
# digit_scan_mux

- Time-multiplexed scan driver for an NDIG-digit common-cathode hex display.
- Holds a displayed value and steps through its digits at a fixed prescaled rate.
- Each slot presents one 4-bit nibble to the downstream hex-to-seven-segment decoder, along with a one-hot digit-enable and a blank flag.
- New values arrive over a valid/ready handshake and are applied only at frame boundaries, so no frame mixes old and new digits.

## Interface
Parameters:
- NDIG, 4: number of digits, ≥2; digit 0 is least significant.
- DIV, 4: clock cycles per digit slot, ≥2.

Ports:
- clk  input  1  single system clock, rising edge.
- nrst  input  1  reset, asynchronous and active-low.
- in_valid  input  1  in_data is offered.
- in_ready  output  1  a new value can be accepted.
- in_data  input  4*NDIG  value to display, digit k in bits [4k+3:4k].
- in_lzb  input  1  leading-zero blanking request, travels with in_data.
- nibble  output  4  hex digit for the segment decoder.
- dig_en  output  NDIG  one-hot digit select, all-zero during the guard cycle.
- blank  output  1  the decoder's segments must be forced off.
- frame_tick  output  1  one-cycle pulse on the last cycle of each frame.

## Operation
- State registers:
  - div_cnt (0..DIV-1)
  - dig (0..NDIG-1)
  - shown, lzb_r: the active value and its blanking flag
  - pend, pend_lzb, pend_v: a one-entry holding buffer
- All outputs depend on registers only; there is no combinational path from any input to any output.
- Prescaler:
  - div_cnt increments every cycle and wraps DIV-1 → 0.
  - On wrap, dig increments and wraps NDIG-1 → 0.
- Boundary: the cycle where dig==NDIG-1 and div_cnt==DIV-1. frame_tick=1 on exactly this cycle.
- Outputs:
  - nibble = shown[4·dig +: 4].
  - dig_en = one-hot(dig) when div_cnt≠0, else all-zero (anti-ghosting guard cycle).
  - blank = 1 when any of these holds:
    - div_cnt==0;
    - lzb_r and dig≥1 and shown bits [4·NDIG-1 : 4·dig] are all zero.
  - Digit 0 is never leading-zero-blanked, so value 0 shows "0".
- Handshake:
  - in_ready = !pend_v.
  - Accept when in_valid && in_ready: pend←in_data, pend_lzb←in_lzb, pend_v←1.
  - in_data must stay stable while in_valid && !in_ready. The block only samples it on accept.
- Transfer at the boundary, when pend_v is 1 at the start of that cycle:
  - On the following edge: shown←pend, lzb_r←pend_lzb, pend_v←0.
- Simultaneous accept and boundary with pend_v=0:
  - The data is stored in pend.
  - It is not transferred at this boundary; it waits for the next one.
- Reset (asynchronous, any time including mid-frame or with pend_v=1):
  - All state clears to 0; the pending value is discarded.
  - Output values: nibble=0, dig_en=0, blank=1, frame_tick=0, in_ready=1.

## Timing
- One frame = NDIG·DIV cycles: 16 at defaults.
- Slot k covers frame cycles [k·DIV, (k+1)·DIV-1].
  - dig_en is active for DIV-1 cycles of the slot.
  - It is preceded by 1 guard cycle.
- First cycle after reset release: dig=0, div_cnt=0 (guard cycle). dig_en=0001 appears on the 2nd cycle.
- Update latency:
  - A value accepted at cycle t becomes shown on the edge ending the first boundary strictly after t.
  - Worst case is one full frame plus one cycle.
- Throughput: at most one value per frame. in_ready stays low from accept until the transfer edge.

## Structure
- Package scan_pkg:
  - typedef hex_digit_t = logic [3:0];
  - NDIG_DEFAULT = 4, DIV_DEFAULT = 4.
  - The one-hot helper function.
- Sub-module scan_prescaler (parameters NDIG, DIV):
  - Contains div_cnt and dig.
  - Outputs dig, guard (div_cnt==0) and boundary.
- The top level holds the handshake buffer, shown/lzb_r, and output muxing.

## Test plan
- Reset, defaults: hold nrst=0 for 3 cycles then release; shown stays 0, lzb=0.
  - During reset: dig_en=0, blank=1, nibble=0, in_ready=1.
  - Then a repeating 16-cycle pattern: 0,0001,0001,0001,0,0010,… with nibble=0.
  - frame_tick every 16th cycle.
- Load 16'h12AF with lzb=0 mid-frame:
  - in_ready drops the next cycle.
  - After the boundary, the slots show nibbles F,A,2,1 on digits 0–3.
  - in_ready returns high.
- Load 16'h0050 with lzb=1:
  - Digits 2 and 3 have blank=1.
  - Digit 1 shows 5 and digit 0 shows 0, both unblanked.
- Load 16'h0000 with lzb=1: only digit 0 is unblanked and shows 0.
- Back-to-back: offer A then B with in_valid held.
  - B is stalled until A transfers, then accepted.
  - Each value is displayed for at least one full frame.
  - Accept on the boundary cycle is deferred one frame.
- Assert nrst mid-frame with pend_v=1:
  - Outputs take reset values immediately, without waiting for a clock edge.
  - The pending value is never displayed.
